// File: rtl/sparc_exu_ecl_cntn.sv
// EXU/ECL sequencing counter: parametrised width, up/down, load, modulo limit,
// wrap or saturate, registered terminal-count pulse and sticky overflow.
module sparc_exu_ecl_cntn #(
    parameter int unsigned WIDTH = 6,
    parameter bit SATURATE = 1'b0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             arst_l,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    input  logic             dn,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] cntr,
    output logic             tc,
    output logic             ovf,
    output logic             at_zero,
    output logic             at_lim
);

    logic [WIDTH-1:0] cntr_q, cntr_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             term_up;
    logic             term_dn;
    logic             term;
    logic [WIDTH-1:0] step_val;

    // Up terminal uses >= so an out-of-range value fires on the next step.
    assign term_up = (cntr_q >= limit);
    assign term_dn = (cntr_q == '0);
    assign term    = dn ? term_dn : term_up;

    always_comb begin
        step_val = cntr_q;
        if (!dn) begin
            if (!term_up)
                step_val = cntr_q + 1'b1;
            else if (SATURATE)
                step_val = limit;
            else
                step_val = '0;
        end else begin
            if (!term_dn)
                step_val = cntr_q - 1'b1;
            else if (SATURATE)
                step_val = '0;
            else
                step_val = limit;
        end
    end

    always_comb begin
        cntr_d = cntr_q;
        tc_d   = 1'b0;
        ovf_d  = ovf_q;
        if (clr) begin
            cntr_d = '0;
            ovf_d  = 1'b0;
        end else if (ld) begin
            cntr_d = ld_val;
        end else if (en) begin
            cntr_d = step_val;
            tc_d   = term;
            ovf_d  = ovf_q | term;
        end
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            cntr_q <= RST_VAL;
            tc_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cntr_q <= cntr_d;
            tc_q   <= tc_d;
            ovf_q  <= ovf_d;
        end
    end

    assign cntr    = cntr_q;
    assign tc      = tc_q;
    assign ovf     = ovf_q;
    assign at_zero = (cntr_q == '0);
    assign at_lim  = (cntr_q == limit);

endmodule

// File: tb/tb_sparc_exu_ecl_cntn.sv
// Directed bench for sparc_exu_ecl_cntn: a wrap instance and a saturate
// instance share one set of stimulus.
module tb_sparc_exu_ecl_cntn;

    logic       clk = 1'b0;
    logic       arst_l;
    logic       clr, ld, en, dn;
    logic [5:0] ld_val, limit;
    logic [5:0] w_cntr, s_cntr;
    logic       w_tc, w_ovf, w_az, w_al;
    logic       s_tc, s_ovf, s_az, s_al;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sparc_exu_ecl_cntn #(.WIDTH(6), .SATURATE(1'b0), .RST_VAL(6'd0)) u_wrap (
        .clk(clk), .arst_l(arst_l), .clr(clr), .ld(ld), .ld_val(ld_val),
        .en(en), .dn(dn), .limit(limit), .cntr(w_cntr), .tc(w_tc),
        .ovf(w_ovf), .at_zero(w_az), .at_lim(w_al)
    );

    sparc_exu_ecl_cntn #(.WIDTH(6), .SATURATE(1'b1), .RST_VAL(6'd0)) u_sat (
        .clk(clk), .arst_l(arst_l), .clr(clr), .ld(ld), .ld_val(ld_val),
        .en(en), .dn(dn), .limit(limit), .cntr(s_cntr), .tc(s_tc),
        .ovf(s_ovf), .at_zero(s_az), .at_lim(s_al)
    );

    typedef struct {
        logic       clr;
        logic       ld;
        logic [5:0] ld_val;
        logic       en;
        logic       dn;
        logic [5:0] lim;
        logic [5:0] e_cntr;
        logic       e_tc;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic c, logic l, logic [5:0] lv, logic e,
                                logic d, logic [5:0] lm, logic [5:0] ec,
                                logic et, logic eo);
        vec_t v;
        v.clr = c; v.ld = l; v.ld_val = lv; v.en = e; v.dn = d;
        v.lim = lm; v.e_cntr = ec; v.e_tc = et; v.e_ovf = eo;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(logic c, logic l, logic [5:0] lv, logic e,
                         logic d, logic [5:0] lm);
        clr = c; ld = l; ld_val = lv; en = e; dn = d; limit = lm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(string n, logic [5:0] c, logic t, logic o);
        chk({n, ".cntr"}, 32'(w_cntr), 32'(c));
        chk({n, ".tc"}, 32'(w_tc), 32'(t));
        chk({n, ".ovf"}, 32'(w_ovf), 32'(o));
    endtask

    task automatic chk_s(string n, logic [5:0] c, logic t, logic o);
        chk({n, ".cntr"}, 32'(s_cntr), 32'(c));
        chk({n, ".tc"}, 32'(s_tc), 32'(t));
        chk({n, ".ovf"}, 32'(s_ovf), 32'(o));
    endtask

    initial begin
        arst_l = 1'b1;
        drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd63);

        // Reset state
        #2 arst_l = 1'b0;
        #1;
        chk_w("rst", 6'd0, 1'b0, 1'b0);
        chk("rst.at_zero", 32'(w_az), 32'd1);
        chk("rst.at_lim", 32'(w_al), 32'd0);
        @(negedge clk);
        arst_l = 1'b1;

        // Legacy free-running 6-bit
        for (int k = 1; k <= 63; k++) begin
            step();
            chk_w($sformatf("leg%0d", k), 6'(k), 1'b0, 1'b0);
        end
        chk("leg63.at_lim", 32'(w_al), 32'd1);
        step();
        chk_w("leg_wrap", 6'd0, 1'b1, 1'b1);
        step();
        chk_w("leg_after", 6'd1, 1'b0, 1'b1);

        // Table: modulo 10, out-of-range load, down wrap, priority, limit edits
        tbl.push_back(mk(1, 0, 0, 1, 0, 9, 0, 0, 0));
        for (int k = 1; k <= 9; k++)
            tbl.push_back(mk(0, 0, 0, 1, 0, 9, 6'(k), 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 9, 0, 1, 1));
        tbl.push_back(mk(0, 1, 12, 0, 0, 9, 12, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 9, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 5, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1, 5, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 5, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 5, 5, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 5, 4, 0, 1));
        tbl.push_back(mk(0, 1, 4, 0, 0, 9, 4, 0, 1));
        tbl.push_back(mk(1, 1, 7, 1, 0, 9, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 9, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3, 1, 0, 9, 3, 0, 0));
        tbl.push_back(mk(0, 1, 9, 0, 0, 9, 9, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 9, 0, 1, 1));
        tbl.push_back(mk(0, 1, 3, 1, 0, 9, 3, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 9, 3, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 2, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].clr, tbl[i].ld, tbl[i].ld_val, tbl[i].en,
                  tbl[i].dn, tbl[i].lim);
            step();
            chk_w($sformatf("tbl%0d", i), tbl[i].e_cntr, tbl[i].e_tc,
                  tbl[i].e_ovf);
            chk($sformatf("tbl%0d.at_zero", i), 32'(w_az),
                32'(tbl[i].e_cntr == 6'd0));
            chk($sformatf("tbl%0d.at_lim", i), 32'(w_al),
                32'(tbl[i].e_cntr == tbl[i].lim));
        end

        // Saturate, up then down
        drive(1, 0, 0, 0, 0, 7);
        step();
        chk_s("sat_clr", 6'd0, 1'b0, 1'b0);
        drive(0, 1, 5, 0, 0, 7);
        step();
        chk_s("sat_ld5", 6'd5, 1'b0, 1'b0);
        drive(0, 0, 0, 1, 0, 7);
        step();
        chk_s("sat_6", 6'd6, 1'b0, 1'b0);
        step();
        chk_s("sat_7a", 6'd7, 1'b0, 1'b0);
        step();
        chk_s("sat_7b", 6'd7, 1'b1, 1'b1);
        step();
        chk_s("sat_7c", 6'd7, 1'b1, 1'b1);
        dn = 1'b1;
        step();
        chk_s("sat_dn6", 6'd6, 1'b0, 1'b1);
        step();
        chk_s("sat_dn5", 6'd5, 1'b0, 1'b1);
        drive(0, 1, 0, 0, 1, 7);
        step();
        drive(0, 0, 0, 1, 1, 7);
        step();
        chk_s("sat_dn0", 6'd0, 1'b1, 1'b1);
        drive(0, 1, 12, 0, 0, 7);
        step();
        drive(0, 0, 0, 1, 0, 7);
        step();
        chk_s("sat_clamp", 6'd7, 1'b1, 1'b1);

        // Asynchronous reset mid-count
        drive(1, 0, 0, 0, 0, 63);
        step();
        drive(0, 0, 0, 1, 0, 63);
        for (int k = 0; k < 17; k++) step();
        chk_w("ar_pre", 6'd17, 1'b0, 1'b0);
        #2 arst_l = 1'b0;
        #1;
        chk_w("ar_now", 6'd0, 1'b0, 1'b0);
        #2 arst_l = 1'b1;
        step();
        chk_w("ar_r1", 6'd1, 1'b0, 1'b0);
        step();
        chk_w("ar_r2", 6'd2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sparc_exu_ecl_cntn.md
Name: sparc_exu_ecl_cntn

Overview:
- Parametrised binary counter for EXU/ECL control sequencing; the next generation of the fixed 6-bit free-running counter.
- Adds programmable width, up/down direction, enable, parallel load, synchronous clear, programmable modulo limit, and wrap or saturate mode.
- Provides a registered terminal-count pulse and a sticky overflow flag.
- WIDTH=6, LIMIT tied to all-ones, en=1, dn=0, SATURATE=0 reproduces the legacy free-running 6-bit counter, apart from reset style.

Parameters:
WIDTH, 6, counter width in bits (2..32)
SATURATE, 0, 0 = wrap at terminal value, 1 = hold at terminal value
RST_VAL, 0, counter value after asynchronous reset (WIDTH bits)

Ports:
clk  input  1  counter clock
arst_l  input  1  asynchronous active-low reset
clr  input  1  synchronous clear; highest priority
ld  input  1  synchronous parallel load
ld_val  input  WIDTH  load value
en  input  1  count enable
dn  input  1  direction: 0 = up, 1 = down
limit  input  WIDTH  modulo terminal value; quasi-static
cntr  output  WIDTH  registered count
tc  output  1  registered one-cycle terminal-count pulse
ovf  output  1  sticky terminal-event flag
at_zero  output  1  combinational: cntr == 0
at_lim  output  1  combinational: cntr == limit

Behaviour:
- Reset: arst_l low asserts asynchronously, at any time including mid-count.
  - cntr = RST_VAL, tc = 0, ovf = 0.
  - Release is synchronous to clk; the first update happens on the first rising edge with arst_l high.
- Update priority per rising edge: clr > ld > en.
  - clr=1: cntr <= 0, tc <= 0, ovf <= 0. ld and en are ignored.
  - clr=0, ld=1: cntr <= ld_val, tc <= 0, ovf holds. ld_val > limit is accepted as-is.
  - clr=0, ld=0, en=1: count step per the rules below.
  - clr=0, ld=0, en=0: cntr holds, tc <= 0.
- Terminal event, defined only for the count step:
  - up: term_up = (cntr >= limit), unsigned compare.
  - down: term_dn = (cntr == 0).
- Count step, up (dn=0):
  - not term_up: cntr <= cntr + 1.
  - term_up, SATURATE=0: cntr <= 0.
  - term_up, SATURATE=1: cntr <= limit, which clamps an out-of-range value.
- Count step, down (dn=1):
  - not term_dn: cntr <= cntr - 1.
  - term_dn, SATURATE=0: cntr <= limit.
  - term_dn, SATURATE=1: cntr <= 0.
- tc:
  - tc <= 1 on the edge where a terminal event is taken; otherwise tc <= 0.
  - Visible the same cycle as the post-event cntr value.
  - In saturate mode, each further enabled cycle at the terminal value re-fires tc.
- ovf:
  - Set on any taken terminal event.
  - Cleared only by clr or reset; ld does not clear it.
- Arithmetic: all WIDTH-bit unsigned; no carry out of the register. limit = 0 up with wrap gives a constant 0 and tc every enabled cycle.
- Direction change takes effect on the next enabled edge; no extra latency.
- at_zero and at_lim are purely combinational from the cntr flops and limit.
- limit changes mid-count: the new value applies at the next edge. If cntr > new limit while counting up, the next step is a terminal event.
- The RTL must not contain a latch or a combinational loop. All outputs except at_zero and at_lim are flop outputs.

Test Plan:
1. Legacy mode (WIDTH=6, limit=63, en=1, dn=0, SATURATE=0) from reset:
   - cntr runs 0..63 then 0.
   - tc=1 only in the cycle cntr=0 after 63.
   - ovf=1 from then until clr.
2. Modulo 10 (limit=9), up, wrap:
   - Sequence 0..9,0.
   - Load ld_val=12, then count: next=0 with tc=1 (out-of-range treated as terminal).
3. Down, wrap, limit=5, start ld_val=1:
   - Sequence 1,0,5,4.
   - tc=1 in the cycle cntr=5.
4. SATURATE=1, up, limit=7, start at 5:
   - Sequence 5,6,7,7,7.
   - tc asserts at each 7 after the first; dn=1 then counts 6,5.
5. Priority and simultaneity:
   - clr=ld=en=1 at cntr=4: next cntr=0, ovf=0, tc=0.
   - ld=en=1, ld_val=3: next cntr=3, ovf unchanged.
6. Asynchronous reset mid-count:
   - Drop arst_l between edges at cntr=17, RST_VAL=0: cntr=0 and tc=0 immediately, without waiting for a clock edge.
   - After release, the count resumes 1,2 on successive edges.
